dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (MemWrite/MemRead strobes, 8-bit Address, 32-bit Write_data/Read_data) between two requesters: the CPU load/store stage and a DMA/debug port.
- Each requester issues one access per request through a req/gnt handshake.
- The block latches the winning request and drives the memory strobes for exactly one cycle.
- It returns read data, or a write acknowledge, through a registered rvalid pulse.

Parameters:
ADDR_W, 8, memory word address width
DATA_W, 32, data word width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
cpu_req  input  1  CPU access request, level, held until cpu_gnt
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  one-cycle grant pulse to CPU
cpu_rvalid  output  1  one-cycle completion pulse to CPU
cpu_rdata  output  DATA_W  read data, valid with cpu_rvalid
dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  same semantics for DMA
dma_gnt, dma_rvalid  output  1  same semantics for DMA
dma_rdata  output  DATA_W  same semantics for DMA
mem_write  output  1  to DataMem MemWrite
mem_read  output  1  to DataMem MemRead
mem_addr  output  ADDR_W  to DataMem Address
mem_wdata  output  DATA_W  to DataMem Write_data
mem_rdata  input  DATA_W  from DataMem Read_data (combinational read)
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: clk rising edge; reset synchronous, active-low (rst_n). All outputs are registered.
- Reset values: all outputs 0, state IDLE, owner register = DMA (so the first tie goes to CPU), latched request cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high, select a winner, latch its we/addr/wdata and the owner, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Winner's gnt = 1.
  - mem_addr/mem_wdata driven from latched values.
  - mem_write = latched we; mem_read = !latched we.
  - For reads, capture mem_rdata into the response register at the end of the cycle.
  - Next state RESP.
- RESP (exactly 1 cycle):
  - Owner's rvalid = 1.
  - Owner's rdata = captured data for reads, 0 for writes.
  - Memory strobes are 0.
  - Next state IDLE.
- Outside these cycles: gnt, rvalid and mem strobes are 0; mem_addr/mem_wdata hold their last values; non-owner rdata holds its last value.
- Latency and throughput: request seen in IDLE at cycle T → gnt and strobe at T+1 → rvalid and rdata at T+2 → IDLE at T+3. One access every 3 cycles under saturation.
- Requester rule: drop req in the cycle after gnt. A req still high when the FSM is back in IDLE counts as a new request.
- Strobe invariant: mem_write and mem_read are never high in the same cycle.
- Request changes while not in IDLE: req/we/addr/wdata changes during ACCESS or RESP have no effect.
- Arbitration (macro absent): fixed priority. CPU wins any tie, and DMA can starve.
- Reset mid-operation: on the next edge with rst_n = 0 the block returns to IDLE with all outputs 0. An in-flight access is dropped with no rvalid. A write strobe already issued is not undone.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant the requester that is not the current owner register. The owner register updates on every grant. A lone requester always wins.
- Undefined: fixed CPU priority, and the owner register only steers the rdata/rvalid routing.

Test Plan:
- CPU write addr 5 data 32, then CPU read addr 5 → mem_write = 1 with addr 5 for one cycle; read gives cpu_rvalid with cpu_rdata = 32 two cycles after the read request; dma outputs stay 0.
- DMA write addr 15 data 104, then DMA read addr 15 → dma_rdata = 104 with dma_rvalid; cpu_gnt/cpu_rvalid never assert.
- CPU and DMA both request reads at addr 5/15 in the same cycle, req held → macro off: CPU, CPU, CPU… (DMA starved while CPU holds req); macro on: CPU, DMA, CPU, DMA, …
- Checker across all tests → mem_write & mem_read never both 1; gnt is exactly 1 cycle; rvalid is exactly 1 cycle after gnt.
- Reset asserted in the ACCESS cycle of a CPU read → next cycle all outputs 0, state IDLE, no cpu_rvalid.
- Changing cpu_addr from 5 to 9 during the ACCESS cycle → mem_addr stays 5 and returned data is from addr 5.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-requester (CPU, DMA) arbiter for a single-port data memory.
//            Optional macro DMEM_ARB_ROUND_ROBIN_EN enables round-robin ties.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic C_OWNER_CPU = 1'b0;
    localparam logic C_OWNER_DMA = 1'b1;

    state_t              state_q,      state_d;
    logic                owner_q,      owner_d;
    logic                lat_we_q,     lat_we_d;
    logic                cpu_gnt_q,    cpu_gnt_d;
    logic                dma_gnt_q,    dma_gnt_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;
    logic                dma_rvalid_q, dma_rvalid_d;
    logic [DATA_W-1:0]   cpu_rdata_q,  cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q,  dma_rdata_d;
    logic                mem_write_q,  mem_write_d;
    logic                mem_read_q,   mem_read_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic                busy_q,       busy_d;

    logic                w_pick_dma;
    logic                w_sel_we;
    logic [DATA_W-1:0]   w_resp_data;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not own the previous access wins.
    assign w_pick_dma = dma_req & (~cpu_req | (owner_q == C_OWNER_CPU));
`else
    assign w_pick_dma = dma_req & ~cpu_req;
`endif

    assign w_sel_we    = w_pick_dma ? dma_we : cpu_we;
    assign w_resp_data = lat_we_q ? '0 : mem_rdata;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_we_d     = lat_we_q;
        cpu_gnt_d    = 1'b0;
        dma_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dma_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d     = S_ACCESS;
                    owner_d     = w_pick_dma ? C_OWNER_DMA : C_OWNER_CPU;
                    lat_we_d    = w_sel_we;
                    mem_addr_d  = w_pick_dma ? dma_addr  : cpu_addr;
                    mem_wdata_d = w_pick_dma ? dma_wdata : cpu_wdata;
                    cpu_gnt_d   = ~w_pick_dma;
                    dma_gnt_d   = w_pick_dma;
                    mem_write_d = w_sel_we;
                    mem_read_d  = ~w_sel_we;
                end
            end
            S_ACCESS: begin
                // Memory read is combinational off mem_addr_q, so capture now.
                state_d = S_RESP;
                if (owner_q == C_OWNER_DMA) begin
                    dma_rvalid_d = 1'b1;
                    dma_rdata_d  = w_resp_data;
                end else begin
                    cpu_rvalid_d = 1'b1;
                    cpu_rdata_d  = w_resp_data;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= C_OWNER_DMA;
            lat_we_q     <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_we_q     <= lat_we_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dma_gnt_q    <= dma_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign dma_gnt    = dma_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign mem_write  = mem_write_q;
    assign mem_read   = mem_read_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req, cpu_we, dma_req, dma_we;
    logic [ADDR_W-1:0] cpu_addr, dma_addr;
    logic [DATA_W-1:0] cpu_wdata, dma_wdata;
    logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] cpu_rdata, dma_rdata;
    logic              mem_write, mem_read, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [DATA_W-1:0] mem [0:255];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    // Protocol monitor sampled mid-cycle.
    logic prev_cg = 1'b0, prev_dg = 1'b0, prev_rst = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (mem_write && mem_read) begin
                miscompares++;
                $display("FAIL strobe_excl: mem_write=%b mem_read=%b required not both 1", mem_write, mem_read);
            end
            vectors++;
            if ((cpu_gnt && prev_cg) || (dma_gnt && prev_dg)) begin
                miscompares++;
                $display("FAIL gnt_width: gnt high two cycles (cpu %b/%b dma %b/%b) required 1 cycle", prev_cg, cpu_gnt, prev_dg, dma_gnt);
            end
            vectors++;
            if (cpu_rvalid !== (prev_cg & prev_rst) || dma_rvalid !== (prev_dg & prev_rst)) begin
                miscompares++;
                $display("FAIL rvalid_follow: cpu_rvalid=%b dma_rvalid=%b required %b %b", cpu_rvalid, dma_rvalid, prev_cg & prev_rst, prev_dg & prev_rst);
            end
        end
        prev_cg  = cpu_gnt;
        prev_dg  = dma_gnt;
        prev_rst = rst_n;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        vectors++;
        if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_write, mem_read, busy} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 0000000", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_write, mem_read, busy});
        end
        vectors++;
        if (mem_addr !== '0 || mem_wdata !== '0 || cpu_rdata !== '0 || dma_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h required all 0", mem_addr, mem_wdata, cpu_rdata, dma_rdata);
        end
        rst_n = 1'b1;
        cyc();
        vectors++;
        if (busy !== 1'b0 || cpu_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b cpu_gnt=%b required 0 0", busy, cpu_gnt);
        end
        chk_en = 1'b1;
    endtask

    task automatic test_cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                                   input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cyc();
        vectors++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL cpu_grant: cpu_gnt=%b dma_gnt=%b busy=%b required 1 0 1", cpu_gnt, dma_gnt, busy);
        end
        vectors++;
        if (mem_write !== we || mem_read !== ~we || mem_addr !== addr || (we && mem_wdata !== wdata)) begin
            miscompares++;
            $display("FAIL cpu_strobe: wr=%b rd=%b addr=%h wdata=%h required %b %b %h %h", mem_write, mem_read, mem_addr, mem_wdata, we, ~we, addr, wdata);
        end
        cpu_req = 1'b0;
        cyc();
        vectors++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_rdata || mem_write !== 1'b0 || mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_resp: rvalid=%b rdata=%h wr=%b rd=%b required 1 %h 0 0", cpu_rvalid, cpu_rdata, mem_write, mem_read, exp_rdata);
        end
        vectors++;
        if (dma_gnt !== 1'b0 || dma_rvalid !== 1'b0 || dma_rdata !== '0) begin
            miscompares++;
            $display("FAIL cpu_dma_quiet: dma gnt=%b rvalid=%b rdata=%h required 0 0 0", dma_gnt, dma_rvalid, dma_rdata);
        end
        cyc();
        vectors++;
        if (busy !== 1'b0 || cpu_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_done: busy=%b rvalid=%b required 0 0", busy, cpu_rvalid);
        end
    endtask

    task automatic test_dma_access(input logic we, input logic [ADDR_W-1:0] addr,
                                   input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata,
                                   input logic [DATA_W-1:0] cpu_hold);
        dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        cyc();
        vectors++;
        if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_write !== we || mem_read !== ~we || mem_addr !== addr) begin
            miscompares++;
            $display("FAIL dma_grant: dgnt=%b cgnt=%b wr=%b rd=%b addr=%h required 1 0 %b %b %h", dma_gnt, cpu_gnt, mem_write, mem_read, mem_addr, we, ~we, addr);
        end
        dma_req = 1'b0;
        cyc();
        vectors++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== exp_rdata || cpu_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL dma_resp: drvalid=%b drdata=%h crvalid=%b required 1 %h 0", dma_rvalid, dma_rdata, cpu_rvalid, exp_rdata);
        end
        vectors++;
        if (cpu_rdata !== cpu_hold) begin
            miscompares++;
            $display("FAIL dma_cpu_hold: cpu_rdata=%h required %h", cpu_rdata, cpu_hold);
        end
        cyc();
    endtask

    task automatic test_arbitration();
        logic exp_dma;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'd15;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_dma = k[0];
`else
            exp_dma = 1'b0;
`endif
            cyc();
            vectors++;
            if (cpu_gnt !== ~exp_dma || dma_gnt !== exp_dma) begin
                miscompares++;
                $display("FAIL arb_grant[%0d]: cgnt=%b dgnt=%b required %b %b", k, cpu_gnt, dma_gnt, ~exp_dma, exp_dma);
            end
            cyc();
            vectors++;
            if (exp_dma ? (dma_rvalid !== 1'b1 || dma_rdata !== 32'd104 || cpu_rvalid !== 1'b0)
                        : (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd32  || dma_rvalid !== 1'b0)) begin
                miscompares++;
                $display("FAIL arb_resp[%0d]: crv=%b crd=%0d drv=%b drd=%0d dma_winner=%b", k, cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata, exp_dma);
            end
            cyc();
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
        cyc();
        vectors++;
        if (cpu_gnt !== 1'b1 || mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_access: cpu_gnt=%b mem_read=%b required 1 1", cpu_gnt, mem_read);
        end
        cpu_req = 1'b0;
        rst_n   = 1'b0;
        cyc();
        vectors++;
        if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_write, mem_read, busy} !== 7'b0 ||
            mem_addr !== '0 || cpu_rdata !== '0 || dma_rdata !== '0) begin
            miscompares++;
            $display("FAIL rstmid_clear: ctrl=%b addr=%h crd=%h drd=%h required all 0", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_write, mem_read, busy}, mem_addr, cpu_rdata, dma_rdata);
        end
        rst_n = 1'b1;
        cyc();
        vectors++;
        if (cpu_rvalid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_norvalid: cpu_rvalid=%b busy=%b required 0 0", cpu_rvalid, busy);
        end
    endtask

    task automatic test_addr_hold();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
        cyc();
        cpu_addr = 8'd9;
        cpu_we   = 1'b1;
        cpu_req  = 1'b0;
        vectors++;
        if (mem_addr !== 8'd5 || mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_access: mem_addr=%0d mem_read=%b required 5 1", mem_addr, mem_read);
        end
        cyc();
        vectors++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd32 || mem_addr !== 8'd5 || mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_resp: rvalid=%b rdata=%0d addr=%0d wr=%b required 1 32 5 0", cpu_rvalid, cpu_rdata, mem_addr, mem_write);
        end
        cpu_we = 1'b0;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        rst_n   = 1'b0;

        test_reset();
        test_cpu_access(1'b1, 8'd5, 32'd32, 32'd0);
        test_cpu_access(1'b0, 8'd5, 32'd0,  32'd32);
        test_dma_access(1'b1, 8'd15, 32'd104, 32'd0,   32'd32);
        test_dma_access(1'b0, 8'd15, 32'd0,   32'd104, 32'd32);
        test_arbitration();
        test_reset_mid();
        test_addr_hold();

        cyc();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
